// File: rtl/compare_seq_pkg.sv
// Shared types, seven-segment codes and operand formatting for the
// DE10-Lite operand compare/display sequencer.
package compare_seq_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    SHOW    = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_ONE   = 8'hF9;

  localparam logic [7:0] SEG_DIGITS [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  // Returns {sign/tens digit, units digit}, DP off. The magnitude never exceeds 9.
  function automatic logic [15:0] format_operand(input logic [3:0] value,
                                                 input logic       twos);
    logic [7:0] hi;
    logic [3:0] mag;
    hi  = SEG_BLANK;
    mag = value;
    if (twos) begin
      if (value[3]) begin
        hi  = SEG_MINUS;
        mag = 4'(~value + 4'd1);
      end
    end else if (value >= 4'd10) begin
      hi  = SEG_ONE;
      mag = value - 4'd10;
    end
    return {hi, SEG_DIGITS[mag]};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces the raw active-low step key and emits a
// one-cycle step pulse on each accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic MAX10_CLK1_50,
  input  logic KEY0,
  input  logic raw_n,
  output logic step
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync;
  logic             stable;
  logic [CNT_W-1:0] count;

  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) sync <= 2'b00;
    else       sync <= {sync[0], raw_n};
  end

  // Resetting to "pressed" keeps a key held through reset from stepping.
  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      stable <= 1'b0;
      count  <= '0;
      step   <= 1'b0;
    end else begin
      step <= 1'b0;
      if (sync[1] == stable) begin
        count <= '0;
      end else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync[1];
        count  <= '0;
        step   <= ~sync[1];
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/compare_sequencer.sv
// Board top level: steps through operand A entry, operand B entry and the
// compare result, driving LEDR and the HEX displays from registers.
module compare_sequencer
  import compare_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5
);

  logic       step;
  logic [4:0] sw_meta, sw_sync;
  logic [3:0] sw_val;
  logic       sw_mode;
  logic       unused_sw;

  state_t     state, state_next;
  logic [3:0] a_reg, a_next, b_reg, b_next;
  logic       mode_reg, mode_next;
  logic [2:0] flags, flags_next;
  logic       a_gt, b_gt;

  logic [15:0] disp_a, disp_b;
  logic [9:0]  ledr_next;

  assign unused_sw = ^SW[8:4];
  assign sw_val    = sw_sync[3:0];
  assign sw_mode   = sw_sync[4];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .KEY0          (KEY0),
    .raw_n         (KEY1),
    .step          (step)
  );

  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= {SW[9], SW[3:0]};
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      state    <= ENTER_A;
      a_reg    <= '0;
      b_reg    <= '0;
      mode_reg <= 1'b0;
      flags    <= '0;
    end else begin
      state    <= state_next;
      a_reg    <= a_next;
      b_reg    <= b_next;
      mode_reg <= mode_next;
      flags    <= flags_next;
    end
  end

  // B is compared live against latched A, in the mode latched with it.
  always_comb begin
    a_gt = sw_mode ? ($signed(a_reg) > $signed(sw_val)) : (a_reg > sw_val);
    b_gt = sw_mode ? ($signed(sw_val) > $signed(a_reg)) : (sw_val > a_reg);
  end

  always_comb begin
    state_next = state;
    a_next     = a_reg;
    b_next     = b_reg;
    mode_next  = mode_reg;
    flags_next = flags;
    if (step) begin
      case (state)
        ENTER_A: begin
          a_next     = sw_val;
          state_next = ENTER_B;
        end
        ENTER_B: begin
          b_next     = sw_val;
          mode_next  = sw_mode;
          flags_next = {~a_gt & ~b_gt, b_gt, a_gt};
          state_next = SHOW;
        end
        SHOW: begin
          a_next     = '0;
          b_next     = '0;
          mode_next  = 1'b0;
          flags_next = '0;
          state_next = ENTER_A;
        end
        default: state_next = ENTER_A;
      endcase
    end
  end

  // Bit 7 cleared on a units digit lights its DP as the entry cursor.
  always_comb begin
    disp_a    = {SEG_BLANK, SEG_BLANK};
    disp_b    = {SEG_BLANK, SEG_BLANK};
    ledr_next = 10'h200;
    case (state)
      ENTER_A: begin
        disp_a    = format_operand(sw_val, sw_mode);
        disp_a[7] = 1'b0;
      end
      ENTER_B: begin
        disp_a    = format_operand(a_reg, sw_mode);
        disp_b    = format_operand(sw_val, sw_mode);
        disp_b[7] = 1'b0;
        ledr_next = 10'h100;
      end
      SHOW: begin
        disp_a    = format_operand(a_reg, mode_reg);
        disp_b    = format_operand(b_reg, mode_reg);
        ledr_next = {3'b001, 4'b0000, flags};
      end
      default: ;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      LEDR <= 10'h200;
      HEX5 <= SEG_BLANK;
      HEX4 <= SEG_BLANK;
      HEX3 <= SEG_BLANK;
      HEX2 <= SEG_BLANK;
      HEX1 <= SEG_BLANK;
      HEX0 <= SEG_BLANK;
    end else begin
      LEDR <= ledr_next;
      HEX5 <= disp_a[15:8];
      HEX4 <= disp_a[7:0];
      HEX3 <= SEG_BLANK;
      HEX2 <= SEG_BLANK;
      HEX1 <= disp_b[15:8];
      HEX0 <= disp_b[7:0];
    end
  end

endmodule

// File: doc/compare_sequencer.md
# compare_sequencer

Sequencer for the DE10-Lite 4-bit operand compare/display datapath. It lets the user enter operand A, then operand B, from a single 4-bit switch field, stepped by a debounced push-button. It then latches the unsigned/two's-complement mode, compares the latched operands, and holds the result on LEDR and the HEX displays until the next step. The block is the board top level and owns the 50 MHz clock domain.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a KEY1 level change (10 ms at 50 MHz).
- MAX10_CLK1_50  in  1  system clock, 50 MHz.
- KEY0  in  1  reset, asynchronous, active-low.
- KEY1  in  1  step button, raw, active-low, asynchronous to the clock.
- SW  in  10  SW[9] mode (0 unsigned, 1 two's complement); SW[3:0] operand entry; SW[8:4] unused.
- LEDR  out  10  [9] ENTER_A, [8] ENTER_B, [7] SHOW (one-hot); [2] A==B; [1] B>A; [0] A>B; [6:3] always 0.
- HEX0..HEX5  out  8 each  active-low segments, bit7 = DP, bits6:0 = g..a. HEX5/HEX4 show A, HEX1/HEX0 show B, HEX3/HEX2 are always 8'hFF.

## Operation
- KEY1 and SW pass through 2-FF synchronizers before any use.
- Debounce: an accepted level change needs DEBOUNCE_CYCLES consecutive cycles at the new level. A high-to-low acceptance emits a one-cycle step pulse. The debouncer resets to the "pressed" state, so a key held through reset produces no step until it is released and pressed again.
- FSM states:
  - ENTER_A: A is a live preview of SW[3:0] in live mode SW[9]; B is blank. On step: A <= SW[3:0]; go to ENTER_B.
  - ENTER_B: A shows the latched A in live mode. B is a live preview. On step: B <= SW[3:0], mode <= SW[9], result flags are computed; go to SHOW.
  - SHOW: A, B, mode and flags are frozen. On step: A, B and mode are cleared to 0; go to ENTER_A.
- Compare rules:
  - Mode 0: both operands are unsigned 0..15.
  - Mode 1: both operands are signed -8..7.
  - Exactly one of LEDR[2:0] is set in SHOW; all three are 0 in ENTER_A and ENTER_B.
- Display per operand (sign/tens digit, units digit):
  - Unsigned: tens digit is "1" (8'hF9) when the value is ≥10, otherwise blank (8'hFF). Units digit is value mod 10.
  - Signed: sign digit is "-" (8'hBF) when negative, otherwise blank. Units digit is the magnitude 0..8.
- Digit codes with DP off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Cursor: in ENTER_A and ENTER_B, the units digit of the operand being entered has DP lit (bit7 = 0).

## Timing
- All outputs are registered.
- Reset (KEY0 low, takes effect immediately and asynchronously):
  - State = ENTER_A; A = B = mode = 0; flags = 0.
  - LEDR = 10'h200; HEX0..HEX5 = 8'hFF.
- First clock edge after reset release: the display shows the preview.
- SW change to display/LED change: 3 cycles (2 synchronizer stages plus the output register).
- Step latency: KEY1 held stable low for DEBOUNCE_CYCLES, then the step pulse. The state change and the latched A/B/flags appear on the following edge. LEDR/HEX reflect the new state 1 cycle after that.
- Steps are processed one per press. A press held indefinitely yields exactly one step.
- Bounce shorter than DEBOUNCE_CYCLES is ignored in either direction.
- SW changes in the same cycle as a step: the synchronized value sampled on the step cycle is latched.
- Reset during any state, including mid-debounce, aborts immediately. The debounce counter clears.

## Structure
- Package compare_seq_pkg holds:
  - The state enum {ENTER_A, ENTER_B, SHOW}.
  - SEG_BLANK = 8'hFF, SEG_MINUS = 8'hBF, SEG_ONE = 8'hF9.
  - The 10-entry digit-code constant array.
- Sub-module key_debounce(MAX10_CLK1_50, KEY0, raw_n, step) contains the synchronizer, the counter and the edge pulse.
- The operand-to-HEX formatting is a function in the package, not a module.

## Test plan
Simulate with DEBOUNCE_CYCLES = 4.
- Reset with KEY0 low -> LEDR = 10'h200, all HEX = FF. Release with SW = 0 -> HEX4 = 8'h40, HEX5 = FF within 3 cycles.
- Unsigned entry: SW[9] = 0, A = 4'hC, step, B = 4'h3, step -> LEDR = 10'h081, HEX5 = F9, HEX4 = A4, HEX1 = FF, HEX0 = B0.
- Signed entry: SW[9] = 1, A = 4'hC, B = 4'h3 -> LEDR = 10'h082, HEX5 = BF, HEX4 = 99, HEX0 = B0.
- Signed equal: A = B = 4'h8 -> LEDR = 10'h084, HEX5 = HEX1 = BF, HEX4 = HEX0 = 80. A further step -> LEDR = 10'h200, B blank.
- Bounce: KEY1 low glitches of 3 cycles -> no state change. KEY1 held low for 20 cycles -> exactly one transition. KEY1 held low through reset release -> no step until released and re-pressed.
- KEY0 pulsed low in ENTER_B, asynchronously between clock edges -> LEDR = 10'h200 and HEX = FF before the next edge. Latched A = 0 afterwards.
